// File: rtl/fu_ctrl_pkg.sv
// Shared encodings for the function-unit control sequencer:
// FS codes, opcode classes, branch conditions and FSM states.
package fu_ctrl_pkg;

   localparam int IMM_W_DEF = 15;
   localparam int OPC_W_DEF = 7;

   localparam logic [4:0] FS_MOVA = 5'b00000;
   localparam logic [4:0] FS_INC  = 5'b00001;
   localparam logic [4:0] FS_ADD  = 5'b00010;
   localparam logic [4:0] FS_ADDC = 5'b00011;
   localparam logic [4:0] FS_ADDN = 5'b00100;
   localparam logic [4:0] FS_SUB  = 5'b00101;
   localparam logic [4:0] FS_DEC  = 5'b00110;
   localparam logic [4:0] FS_MOVB = 5'b00111;
   localparam logic [4:0] FS_AND  = 5'b01000;
   localparam logic [4:0] FS_OR   = 5'b01001;
   localparam logic [4:0] FS_XOR  = 5'b01010;
   localparam logic [4:0] FS_NOT  = 5'b01011;
   localparam logic [4:0] FS_SHR  = 5'b10000;
   localparam logic [4:0] FS_SHL  = 5'b10001;

   localparam logic [1:0] CLS_ALU_R  = 2'b00;
   localparam logic [1:0] CLS_ALU_I  = 2'b01;
   localparam logic [1:0] CLS_BRANCH = 2'b10;
   localparam logic [1:0] CLS_MEM    = 2'b11;

   localparam logic [2:0] BR_Z  = 3'b000;
   localparam logic [2:0] BR_NZ = 3'b001;
   localparam logic [2:0] BR_N  = 3'b010;
   localparam logic [2:0] BR_LT = 3'b011;
   localparam logic [2:0] BR_V  = 3'b100;
   localparam logic [2:0] BR_AL = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DECODE = 2'b01,
      EXEC   = 2'b10,
      WB     = 2'b11
   } state_t;

   function automatic logic fs_legal(input logic [4:0] f);
      return (f <= FS_NOT) || (f == FS_SHR) || (f == FS_SHL);
   endfunction

endpackage

// File: rtl/fu_branch_cond.sv
// Branch condition evaluation from the latched function-unit flags.
module fu_branch_cond
   import fu_ctrl_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       z,
   input  logic       n,
   input  logic       v,
   input  logic       nxv,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (cond)
         BR_Z:    taken = z;
         BR_NZ:   taken = ~z;
         BR_N:    taken = n;
         BR_LT:   taken = nxv;
         BR_V:    taken = v;
         BR_AL:   taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/fu_control_sequencer.sv
// Four-cycle sequencer: accept, decode, execute/sample flags,
// then one write-back, store, branch or illegal strobe.
module fu_control_sequencer
   import fu_ctrl_pkg::*;
#(
   parameter int IMM_W = IMM_W_DEF,
   parameter int OPC_W = OPC_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ins_valid,
   output logic        ins_ready,
   input  logic [31:0] ins_word,
   input  logic        fu_z,
   input  logic        fu_n,
   input  logic        fu_v,
   input  logic        fu_nxv,
   output logic [4:0]  fs,
   output logic [4:0]  sh,
   output logic [4:0]  da,
   output logic [4:0]  aa,
   output logic [4:0]  ba,
   output logic        mb,
   output logic [31:0] imm_out,
   output logic        rw,
   output logic        mw,
   output logic        br_valid,
   output logic        br_taken,
   output logic        illegal
);

   state_t            state;
   logic [31:0]       ins_q;
   logic [3:0]        flags_q;
   logic [OPC_W-1:0]  opc;
   logic [1:0]        cls;
   logic [4:0]        dec_fs;
   logic              dec_mb;
   logic              dec_legal;
   logic              dec_wr;
   logic              dec_st;
   logic              dec_br;
   logic              cond_taken;

   assign opc = ins_q[31 -: OPC_W];
   assign cls = opc[6:5];

   always_comb begin
      dec_fs    = FS_MOVA;
      dec_mb    = 1'b0;
      dec_legal = 1'b0;
      dec_wr    = 1'b0;
      dec_st    = 1'b0;
      dec_br    = 1'b0;
      case (cls)
         CLS_ALU_R, CLS_ALU_I: begin
            dec_legal = fs_legal(opc[4:0]);
            dec_fs    = opc[4:0];
            dec_mb    = (cls == CLS_ALU_I);
            dec_wr    = 1'b1;
         end
         CLS_BRANCH: begin
            dec_legal = (opc[2:0] <= BR_AL);
            dec_fs    = FS_SUB;
            dec_br    = 1'b1;
         end
         default: begin
            dec_legal = (opc[4:1] == 4'b0000);
            dec_fs    = FS_ADD;
            dec_mb    = 1'b1;
            dec_wr    = ~opc[0];
            dec_st    = opc[0];
         end
      endcase
      // Illegal words must not drive a meaningful operation
      if (!dec_legal) begin
         dec_fs = FS_MOVA;
         dec_mb = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ins_q     <= '0;
         flags_q   <= '0;
         ins_ready <= 1'b1;
         fs        <= '0;
         sh        <= '0;
         da        <= '0;
         aa        <= '0;
         ba        <= '0;
         mb        <= 1'b0;
         imm_out   <= '0;
         rw        <= 1'b0;
         mw        <= 1'b0;
         br_valid  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         rw       <= 1'b0;
         mw       <= 1'b0;
         br_valid <= 1'b0;
         illegal  <= 1'b0;
         case (state)
            IDLE: begin
               if (ins_valid && ins_ready) begin
                  ins_q     <= ins_word;
                  ins_ready <= 1'b0;
                  state     <= DECODE;
               end
            end
            DECODE: begin
               fs      <= dec_fs;
               sh      <= ins_q[14:10];
               da      <= ins_q[24:20];
               aa      <= ins_q[19:15];
               ba      <= ins_q[14:10];
               mb      <= dec_mb;
               imm_out <= {{(32-IMM_W){1'b0}}, ins_q[IMM_W-1:0]};
               state   <= EXEC;
            end
            EXEC: begin
               flags_q  <= {fu_z, fu_n, fu_v, fu_nxv};
               rw       <= dec_legal & dec_wr;
               mw       <= dec_legal & dec_st;
               br_valid <= dec_legal & dec_br;
               illegal  <= ~dec_legal;
               state    <= WB;
            end
            default: begin
               ins_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   fu_branch_cond u_cond (
      .cond  (ins_q[27:25]),
      .z     (flags_q[3]),
      .n     (flags_q[2]),
      .v     (flags_q[1]),
      .nxv   (flags_q[0]),
      .taken (cond_taken)
   );

   assign br_taken = br_valid & cond_taken;

endmodule

// File: tb/tb_fu_control_sequencer.sv
// Directed bench for fu_control_sequencer with a scoreboard of
// expected write-back strobes and decoded controls.
module tb_fu_control_sequencer;

   typedef struct packed {
      logic [4:0] fs;
      logic       mb;
      logic       rw;
      logic       mw;
      logic       bv;
      logic       bt;
      logic       il;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins_word;
   logic        fu_z, fu_n, fu_v, fu_nxv;
   logic [4:0]  fs, sh, da, aa, ba;
   logic        mb;
   logic [31:0] imm_out;
   logic        rw, mw, br_valid, br_taken, illegal;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   fu_control_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ins_valid (ins_valid),
      .ins_ready (ins_ready),
      .ins_word  (ins_word),
      .fu_z      (fu_z),
      .fu_n      (fu_n),
      .fu_v      (fu_v),
      .fu_nxv    (fu_nxv),
      .fs        (fs),
      .sh        (sh),
      .da        (da),
      .aa        (aa),
      .ba        (ba),
      .mb        (mb),
      .imm_out   (imm_out),
      .rw        (rw),
      .mw        (mw),
      .br_valid  (br_valid),
      .br_taken  (br_taken),
      .illegal   (illegal)
   );

   function automatic exp_t mk(input logic [4:0] f, input logic m,
                               input logic r, input logic w,
                               input logic bv, input logic bt,
                               input logic il);
      exp_t e;
      e = '{fs: f, mb: m, rw: r, mw: w, bv: bv, bt: bt, il: il};
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] w, input exp_t ex,
                        input logic [3:0] fx, input logic [3:0] fw);
      exp_t e;
      int   k;
      @(negedge clk);
      check("ready_idle", ins_ready, 1);
      ins_valid = 1'b1;
      ins_word  = w;
      sb.push_back(ex);
      @(posedge clk);
      #1 ins_valid = 1'b0;
      @(negedge clk);
      check("decode_quiet", {rw, mw, br_valid, illegal, ins_ready}, 0);
      @(negedge clk);
      {fu_z, fu_n, fu_v, fu_nxv} = fx;
      check("exec_quiet", {rw, mw, br_valid, illegal, ins_ready}, 0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(rw | mw | br_valid | illegal) && k < 6);
      check("wb_latency", k, 1);
      {fu_z, fu_n, fu_v, fu_nxv} = fw;
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("wb_fs", fs, e.fs);
         check("wb_mb", mb, e.mb);
         check("wb_strobes", {rw, mw, br_valid, br_taken, illegal},
               {e.rw, e.mw, e.bv, e.bt, e.il});
      end
      @(negedge clk);
      check("post_wb_quiet", {rw, mw, br_valid, illegal}, 0);
      check("post_wb_ready", ins_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      int wc;
      int sc;
      rst_n     = 1'b0;
      ins_valid = 1'b0;
      ins_word  = '0;
      {fu_z, fu_n, fu_v, fu_nxv} = 4'b0000;
      repeat (2) @(negedge clk);
      check("rst_ready", ins_ready, 1);
      check("rst_outs", {rw, mw, br_valid, br_taken, illegal, mb}, 0);
      check("rst_fs", fs, 0);
      check("rst_imm", imm_out, 0);
      rst_n = 1'b1;

      // ALU reg ADD, DA=3 AA=1 BA=2
      issue({7'b0000010, 5'd3, 5'd1, 5'd2, 10'd0},
            mk(5'b00010, 0, 1, 0, 0, 0, 0), 4'b0000, 4'b0000);
      check("add_da", da, 3);
      check("add_aa", aa, 1);
      check("add_ba", ba, 2);

      // shift with immediate, sh=7
      issue({7'b0110000, 5'd4, 5'd5, 5'd7, 10'd0},
            mk(5'b10000, 1, 1, 0, 0, 0, 0), 4'b0000, 4'b0000);
      check("shi_sh", sh, 7);
      check("shi_imm", imm_out, 32'h0000_1C00);

      issue({7'b0101000, 5'd1, 5'd2, 15'h7FFF},
            mk(5'b01000, 1, 1, 0, 0, 0, 0), 4'b0000, 4'b0000);
      check("andi_imm", imm_out, 32'h0000_7FFF);

      // BLT: N^V set in EXEC, cleared in WB
      issue({7'b1000011, 5'd0, 5'd1, 5'd2, 10'd0},
            mk(5'b00101, 0, 0, 0, 1, 1, 0), 4'b0001, 4'b0000);
      issue({7'b1000000, 5'd0, 5'd1, 5'd2, 10'd0},
            mk(5'b00101, 0, 0, 0, 1, 0, 0), 4'b0000, 4'b1000);
      issue({7'b1000001, 5'd0, 5'd1, 5'd2, 10'd0},
            mk(5'b00101, 0, 0, 0, 1, 1, 0), 4'b0000, 4'b1000);
      issue({7'b1000100, 5'd0, 5'd1, 5'd2, 10'd0},
            mk(5'b00101, 0, 0, 0, 1, 1, 0), 4'b0010, 4'b0000);
      issue({7'b1000101, 5'd0, 5'd1, 5'd2, 10'd0},
            mk(5'b00101, 0, 0, 0, 1, 1, 0), 4'b0000, 4'b0000);

      issue({7'b1100000, 5'd6, 5'd1, 15'd8},
            mk(5'b00010, 1, 1, 0, 0, 0, 0), 4'b0000, 4'b0000);
      issue({7'b1100001, 5'd0, 5'd1, 15'd8},
            mk(5'b00010, 1, 0, 1, 0, 0, 0), 4'b0000, 4'b0000);

      issue({7'b0001100, 5'd1, 5'd1, 5'd1, 10'd0},
            mk(5'b00000, 0, 0, 0, 0, 0, 1), 4'b0000, 4'b0000);
      issue({7'b1000110, 5'd1, 5'd1, 5'd1, 10'd0},
            mk(5'b00000, 0, 0, 0, 0, 0, 1), 4'b0001, 4'b0001);
      issue({7'b1100010, 5'd1, 5'd1, 5'd1, 10'd0},
            mk(5'b00000, 0, 0, 0, 0, 0, 1), 4'b0000, 4'b0000);
      issue({7'b0010010, 5'd1, 5'd1, 5'd1, 10'd0},
            mk(5'b00000, 0, 0, 0, 0, 0, 1), 4'b0000, 4'b0000);

      // reset asserted during EXEC
      @(negedge clk);
      ins_valid = 1'b1;
      ins_word  = {7'b0000010, 5'd3, 5'd1, 5'd2, 10'd0};
      @(posedge clk);
      #1 ins_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_ready", ins_ready, 1);
      check("abort_quiet", {rw, mw, br_valid, illegal}, 0);
      check("abort_fs", fs, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sc = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         sc += int'(rw | mw | br_valid | illegal);
      end
      check("abort_no_pulse", sc, 0);

      // continuous ins_valid: one accept every four cycles
      @(negedge clk);
      ins_valid = 1'b1;
      ins_word  = {7'b0000010, 5'd3, 5'd1, 5'd2, 10'd0};
      rc = 0;
      wc = 0;
      for (int i = 0; i < 12; i++) begin
         rc += int'(ins_ready);
         wc += int'(rw);
         @(negedge clk);
      end
      ins_valid = 1'b0;
      check("hs_ready_cnt", rc, 3);
      check("hs_rw_cnt", wc, 3);
      repeat (5) @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
